// File: rtl/adc_burst_framer.sv
// Burst framer: buffers each contiguous run of ADC samples and replays it as one
// AXI-Stream frame (header word, samples, tlast on the final sample).
module adc_burst_framer #(
  parameter int DATA_WIDTH = 128,
  parameter int FIFO_AW    = 10,
  parameter int DESC_AW    = 3,
  parameter int MAX_BURST  = 4096
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic [15:0]           frames_sent,
  output logic [31:0]           overflow_count,
  output logic [15:0]           bursts_dropped,
  output logic [FIFO_AW:0]      fifo_level
);

  localparam int          DEPTH   = 1 << FIFO_AW;
  localparam int          DDEPTH  = 1 << DESC_AW;
  localparam int          DESC_W  = 112;
  localparam logic [31:0] MAX_LEN = 32'(MAX_BURST);

  typedef enum logic [1:0] {IN_IDLE, IN_COLLECT, IN_DISCARD} in_state_e;
  typedef enum logic [1:0] {OUT_IDLE, OUT_HEADER, OUT_DATA} out_state_e;

  in_state_e  in_state_q;
  out_state_e out_state_q;

  logic [63:0] first_q;
  logic [31:0] len_q;
  logic        trunc_q;
  logic [14:0] burst_id_q;
  logic [31:0] ovf_q;
  logic [15:0] dropped_q;
  logic [15:0] frames_q;

  logic [DATA_WIDTH-1:0] dmem_q [DEPTH];
  logic [FIFO_AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]      level_q;

  logic [DESC_W-1:0]  desc_mem_q [DDEPTH];
  logic [DESC_AW-1:0] dwr_ptr_q, drd_ptr_q;
  logic [DESC_AW:0]   dcount_q;

  logic [DATA_WIDTH-1:0] tdata_q;
  logic                  tvalid_q, tlast_q, tuser_q;
  logic [31:0]           remain_q;

  logic              data_wr, data_rd, desc_push, desc_pop;
  logic              data_room, desc_room, drop_word, drop_burst;
  logic [DESC_W-1:0] desc_wdata, desc_rdata;

  // A descriptor is retired only when its tlast handshakes, so the descriptor
  // FIFO bounds the number of outstanding frames, including the one in flight.
  assign data_rd   = m_axis_tready &&
                     (out_state_q == OUT_HEADER || (out_state_q == OUT_DATA && !tlast_q));
  assign desc_pop  = m_axis_tready && out_state_q == OUT_DATA && tlast_q;
  assign data_room = !level_q[FIFO_AW] || data_rd;
  assign desc_room = !dcount_q[DESC_AW] || desc_pop;

  assign desc_rdata = desc_mem_q[drd_ptr_q];
  assign desc_wdata = {trunc_q, burst_id_q, s_axis_tvalid ? len_q + 32'd1 : len_q, first_q};

  always_comb begin
    data_wr    = 1'b0;
    desc_push  = 1'b0;
    drop_word  = 1'b0;
    drop_burst = 1'b0;
    case (in_state_q)
      IN_IDLE: begin
        if (s_axis_tvalid) begin
          if (desc_room) begin
            data_wr   = data_room;
            drop_word = !data_room;
          end else begin
            drop_word  = 1'b1;
            drop_burst = 1'b1;
          end
        end
      end
      IN_COLLECT: begin
        if (s_axis_tvalid) begin
          data_wr   = data_room;
          drop_word = !data_room;
          desc_push = data_room && (len_q + 32'd1 == MAX_LEN);
        end else begin
          desc_push  = (len_q != 32'd0);
          drop_burst = (len_q == 32'd0);
        end
      end
      IN_DISCARD: drop_word = s_axis_tvalid;
      default: ;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      in_state_q <= IN_IDLE;
      first_q    <= '0;
      len_q      <= '0;
      trunc_q    <= 1'b0;
      burst_id_q <= '0;
      ovf_q      <= '0;
      dropped_q  <= '0;
    end else begin
      case (in_state_q)
        IN_IDLE: begin
          if (s_axis_tvalid) begin
            if (desc_room) begin
              in_state_q <= IN_COLLECT;
              first_q    <= s_axis_tdata[127:64];
              len_q      <= {31'd0, data_wr};
              trunc_q    <= !data_wr;
            end else begin
              in_state_q <= IN_DISCARD;
            end
          end
        end
        IN_COLLECT: begin
          if (!s_axis_tvalid || desc_push) in_state_q <= IN_IDLE;
          else if (data_wr)                len_q      <= len_q + 32'd1;
          else                             trunc_q    <= 1'b1;
        end
        IN_DISCARD: if (!s_axis_tvalid) in_state_q <= IN_IDLE;
        default: in_state_q <= IN_IDLE;
      endcase
      if (desc_push) burst_id_q <= burst_id_q + 15'd1;
      if (drop_word && ovf_q != 32'hFFFF_FFFF) ovf_q <= ovf_q + 32'd1;
      if (drop_burst) dropped_q <= dropped_q + 16'd1;
    end
  end

  always_ff @(posedge aclk) begin
    if (data_wr)   dmem_q[wr_ptr_q]       <= s_axis_tdata;
    if (desc_push) desc_mem_q[dwr_ptr_q]  <= desc_wdata;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      dwr_ptr_q <= '0;
      drd_ptr_q <= '0;
      dcount_q  <= '0;
    end else begin
      if (data_wr)   wr_ptr_q  <= wr_ptr_q + FIFO_AW'(1);
      if (data_rd)   rd_ptr_q  <= rd_ptr_q + FIFO_AW'(1);
      if (desc_push) dwr_ptr_q <= dwr_ptr_q + DESC_AW'(1);
      if (desc_pop)  drd_ptr_q <= drd_ptr_q + DESC_AW'(1);
      case ({data_wr, data_rd})
        2'b10:   level_q <= level_q + (FIFO_AW+1)'(1);
        2'b01:   level_q <= level_q - (FIFO_AW+1)'(1);
        default: ;
      endcase
      case ({desc_push, desc_pop})
        2'b10:   dcount_q <= dcount_q + (DESC_AW+1)'(1);
        2'b01:   dcount_q <= dcount_q - (DESC_AW+1)'(1);
        default: ;
      endcase
    end
  end

  // The next sample is loaded into the output register on each accepted word,
  // giving one word per cycle while tready stays high.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      out_state_q <= OUT_IDLE;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tuser_q     <= 1'b0;
      remain_q    <= '0;
      frames_q    <= '0;
    end else begin
      case (out_state_q)
        OUT_IDLE: begin
          if (dcount_q != '0) begin
            tdata_q     <= {16'hB0F5, desc_rdata};
            tvalid_q    <= 1'b1;
            tuser_q     <= 1'b1;
            tlast_q     <= 1'b0;
            remain_q    <= desc_rdata[95:64];
            out_state_q <= OUT_HEADER;
          end
        end
        OUT_HEADER: begin
          if (m_axis_tready) begin
            tdata_q     <= dmem_q[rd_ptr_q];
            tuser_q     <= 1'b0;
            tlast_q     <= (remain_q == 32'd1);
            remain_q    <= remain_q - 32'd1;
            out_state_q <= OUT_DATA;
          end
        end
        OUT_DATA: begin
          if (m_axis_tready) begin
            if (tlast_q) begin
              tvalid_q    <= 1'b0;
              tlast_q     <= 1'b0;
              frames_q    <= frames_q + 16'd1;
              out_state_q <= OUT_IDLE;
            end else begin
              tdata_q  <= dmem_q[rd_ptr_q];
              tlast_q  <= (remain_q == 32'd1);
              remain_q <= remain_q - 32'd1;
            end
          end
        end
        default: out_state_q <= OUT_IDLE;
      endcase
    end
  end

  assign m_axis_tvalid  = tvalid_q;
  assign m_axis_tdata   = tdata_q;
  assign m_axis_tlast   = tlast_q;
  assign m_axis_tuser   = tuser_q;
  assign frames_sent    = frames_q;
  assign overflow_count = ovf_q;
  assign bursts_dropped = dropped_q;
  assign fifo_level     = level_q;

endmodule
